ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 31 +++
 rtl/ram_arbiter.sv | 92 +++++++++
 tb/tb_ram_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signal bundle for the two-port RAM arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic                  req_a, req_b;
  logic                  we_a, we_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [DATA_WIDTH-1:0] wdata_a, wdata_b;
  logic                  gnt_a, gnt_b;
  logic                  rvalid_a, rvalid_b;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic                  busy;
  logic                  ram_wren, ram_rden;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_rd_data,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, err, busy,
           ram_wren, ram_rden, ram_addr, ram_wr_data
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_rd_data,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata, err, busy,
           ram_wren, ram_rden, ram_addr, ram_wr_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 8
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD, RDRET} state_t;

  state_t                state, state_nxt;
  logic                  prio_b, owner_b, oor_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  any_req, pick_b, sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  gnt, rvalid, err, wren, rden;

  // B wins when it is alone or when both ask and B holds priority
  assign any_req   = bus.req_a | bus.req_b;
  assign pick_b    = bus.req_b & (~bus.req_a | prio_b);
  assign sel_we    = pick_b ? bus.we_b    : bus.we_a;
  assign sel_addr  = pick_b ? bus.addr_b  : bus.addr_a;
  assign sel_wdata = pick_b ? bus.wdata_b : bus.wdata_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      prio_b  <= 1'b0;
      owner_b <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        owner_b <= pick_b;
        prio_b  <= ~pick_b;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        oor_q   <= {1'b0, sel_addr} >= DEPTH;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    rvalid    = 1'b0;
    err       = 1'b0;
    wren      = 1'b0;
    rden      = 1'b0;
    case (state)
      IDLE: if (any_req) state_nxt = sel_we ? WR : RD;
      WR: begin
        gnt       = 1'b1;
        err       = oor_q;
        wren      = ~oor_q;
        state_nxt = IDLE;
      end
      RD: begin
        gnt       = 1'b1;
        err       = oor_q;
        rden      = ~oor_q;
        state_nxt = oor_q ? IDLE : RDRET;
      end
      RDRET: begin
        rvalid    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.gnt_a       = gnt & ~owner_b;
  assign bus.gnt_b       = gnt &  owner_b;
  assign bus.rvalid_a    = rvalid & ~owner_b;
  assign bus.rvalid_b    = rvalid &  owner_b;
  assign bus.rdata       = bus.ram_rd_data;
  assign bus.err         = err;
  assign bus.busy        = (state != IDLE);
  assign bus.ram_wren    = wren;
  assign bus.ram_rden    = rden;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wr_data = wdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed vector bench for ram_arbiter with a behavioural registered-read RAM.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  ram_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

  ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .MEM_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wr_data;
    if (bus.ram_rden) bus.ram_rd_data <= mem[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Protocol invariants sampled every cycle out of reset
  logic pg_a = 1'b0, pg_b = 1'b0, pv_a = 1'b0, pv_b = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      chk("dual_strobe", {31'b0, bus.ram_wren & bus.ram_rden}, 32'd0);
      chk("dual_gnt", {31'b0, bus.gnt_a & bus.gnt_b}, 32'd0);
      chk("gnt_a_pulse", {31'b0, bus.gnt_a & pg_a}, 32'd0);
      chk("gnt_b_pulse", {31'b0, bus.gnt_b & pg_b}, 32'd0);
      chk("rv_a_pulse", {31'b0, bus.rvalid_a & pv_a}, 32'd0);
      chk("rv_b_pulse", {31'b0, bus.rvalid_b & pv_b}, 32'd0);
      if (bus.gnt_a | bus.gnt_b | bus.rvalid_a | bus.rvalid_b)
        chk("busy_active", {31'b0, bus.busy}, 32'd1);
    end
    pg_a = rst & bus.gnt_a;
    pg_b = rst & bus.gnt_b;
    pv_a = rst & bus.rvalid_a;
    pv_b = rst & bus.rvalid_b;
  end

  typedef struct {
    logic        ra, wa, rb, wb;
    logic [3:0]  aa, ab;
    logic [15:0] da, db;
    logic [7:0]  fl;   // {gnt_a,gnt_b,rvalid_a,rvalid_b,err,wren,rden,busy}
    logic [3:0]  ea;   // ram_addr, checked on grant cycles
    logic [15:0] ed;   // wr_data on wren, rdata on rvalid
  } vec_t;

  function automatic vec_t mk(int ra, int wa, int aa, int da, int rb, int wb, int ab, int db,
                              int fl, int ea, int ed);
    vec_t v;
    v.ra = ra[0]; v.wa = wa[0]; v.aa = 4'(aa); v.da = 16'(da);
    v.rb = rb[0]; v.wb = wb[0]; v.ab = 4'(ab); v.db = 16'(db);
    v.fl = 8'(fl); v.ea = 4'(ea); v.ed = 16'(ed);
    return v;
  endfunction

  function automatic logic [7:0] flags();
    return {bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b,
            bus.err, bus.ram_wren, bus.ram_rden, bus.busy};
  endfunction

  task automatic drive(input vec_t v);
    bus.req_a = v.ra; bus.we_a = v.wa; bus.addr_a = v.aa; bus.wdata_a = v.da;
    bus.req_b = v.rb; bus.we_b = v.wb; bus.addr_b = v.ab; bus.wdata_b = v.db;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t tbl [22];
  vec_t idle_v;
  int   got [4];
  int   n, cyc;

  initial begin
    idle_v = mk(0,0,0,0, 0,0,0,0, 'b0, 0,0);
    //            A: req we addr data      B: req we addr data     flags        ea  ed
    tbl[0]  = mk(1,1,3,'h1234, 0,0,0,0,      'b00000000, 0,0);
    tbl[1]  = mk(1,1,3,'h1234, 1,0,3,0,      'b10000101, 3,'h1234);
    tbl[2]  = mk(0,0,0,0,      1,0,3,0,      'b00000000, 0,0);
    tbl[3]  = mk(0,0,0,0,      1,0,3,0,      'b01000011, 3,0);
    tbl[4]  = mk(0,0,0,0,      0,0,0,0,      'b00010001, 0,'h1234);
    tbl[5]  = mk(1,0,9,0,      0,0,0,0,      'b00000000, 0,0);
    tbl[6]  = mk(1,0,9,0,      0,0,0,0,      'b10001001, 9,0);
    tbl[7]  = mk(1,1,1,'h00A1, 1,1,2,'h00B2, 'b00000000, 0,0);
    tbl[8]  = mk(1,1,1,'h00A1, 0,0,0,0,      'b01000101, 2,'h00B2);
    tbl[9]  = mk(1,1,1,'h00A1, 0,0,0,0,      'b00000000, 0,0);
    tbl[10] = mk(0,0,0,0,      1,0,1,0,      'b10000101, 1,'h00A1);
    tbl[11] = mk(1,0,2,0,      1,0,1,0,      'b00000000, 0,0);
    tbl[12] = mk(1,0,2,0,      0,0,0,0,      'b01000011, 1,0);
    tbl[13] = mk(1,0,2,0,      0,0,0,0,      'b00010001, 0,'h00A1);
    tbl[14] = mk(1,0,2,0,      0,0,0,0,      'b00000000, 0,0);
    tbl[15] = mk(0,0,0,0,      0,0,0,0,      'b10000011, 2,0);
    tbl[16] = mk(0,0,0,0,      0,0,0,0,      'b00100001, 0,'h00B2);
    tbl[17] = mk(0,0,0,0,      1,1,7,'h7777, 'b00000000, 0,0);
    tbl[18] = mk(1,1,8,'h8888, 0,0,0,0,      'b01000101, 7,'h7777);
    tbl[19] = mk(1,1,8,'h8888, 0,0,0,0,      'b00000000, 0,0);
    tbl[20] = mk(0,0,0,0,      0,0,0,0,      'b10001001, 8,0);
    tbl[21] = mk(0,0,0,0,      0,0,0,0,      'b00000000, 0,0);

    drive(idle_v);
    bus.ram_rd_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state, with a request pending that must not be granted
    bus.req_a = 1'b1;
    #12;
    chk("reset_flags", {24'b0, flags()}, 32'd0);
    @(negedge clk);
    chk("reset_hold_flags", {24'b0, flags()}, 32'd0);
    bus.req_a = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d flags", i), {24'b0, flags()}, {24'b0, tbl[i].fl});
      if (tbl[i].fl[7] | tbl[i].fl[6])
        chk($sformatf("v%0d ram_addr", i), {28'b0, bus.ram_addr}, {28'b0, tbl[i].ea});
      if (tbl[i].fl[2])
        chk($sformatf("v%0d wr_data", i), {16'b0, bus.ram_wr_data}, {16'b0, tbl[i].ed});
      if (tbl[i].fl[5] | tbl[i].fl[4])
        chk($sformatf("v%0d rdata", i), {16'b0, bus.rdata}, {16'b0, tbl[i].ed});
    end

    // Continuous contention from reset: grants must alternate A,B,A,B
    do_reset();
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 4'd4; bus.wdata_a = 16'h0A0A;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 4'd5; bus.wdata_b = 16'h0B0B;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
      if (bus.gnt_a) begin got[n] = 0; n++; end
      else if (bus.gnt_b) begin got[n] = 1; n++; end
    end
    drive(idle_v);
    chk("contention_count", n, 4);
    for (int i = 0; i < n; i++)
      chk($sformatf("contention_order%0d", i), got[i], i % 2);

    // Reset during RD aborts the read and returns priority to A
    @(negedge clk);
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 4'd5;
    @(negedge clk);
    #1;
    chk("abort_gnt_a", {31'b0, bus.gnt_a}, 32'd1);
    chk("abort_rden", {31'b0, bus.ram_rden}, 32'd1);
    rst = 1'b0;
    bus.req_a = 1'b0;
    #1;
    chk("abort_rden_low", {31'b0, bus.ram_rden}, 32'd0);
    chk("abort_busy_low", {31'b0, bus.busy}, 32'd0);
    chk("abort_gnt_low", {31'b0, bus.gnt_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort_quiet%0d", i), {24'b0, flags()}, 32'd0);
    end
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 4'd4;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 4'd5;
    @(negedge clk);
    #1;
    chk("post_reset_gnt", {30'b0, bus.gnt_a, bus.gnt_b}, 32'd2);
    drive(idle_v);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
